// File: rtl/sfence_vma_ctrl_pkg.sv
// Shared types for the SFENCE.VMA sequencer.
//   sfence_state_e : controller states
//   sfence_req_t   : operands captured at issue (vaddr, ASID, global flags, scoreboard id)
package sfence_vma_ctrl_pkg;

  localparam int unsigned VLEN           = 64;
  localparam int unsigned TRANS_ID_BITS  = 3;
  // Upper bound on the ASID width a design may configure.
  localparam int unsigned ASID_MAX_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    WAIT_COMMIT,
    DRAIN,
    FLUSH
  } sfence_state_e;

  typedef struct packed {
    logic [VLEN-1:0]           vaddr;
    logic [ASID_MAX_WIDTH-1:0] asid;
    logic                      all_vaddr;
    logic                      all_asid;
    logic [TRANS_ID_BITS-1:0]  trans_id;
  } sfence_req_t;

endpackage

// File: rtl/sfence_vma_ctrl_sat_counter.sv
// Saturating up-counter used as the store-drain timer.
//   clk_i/rst_ni : clock, async active-low reset
//   clr_i        : synchronous clear (priority over en_i)
//   en_i         : count up by one, stop at MAX_VALUE
//   cnt_o        : current count
//   sat_o        : count has reached MAX_VALUE
module sfence_vma_ctrl_sat_counter #(
  parameter int unsigned MAX_VALUE = 256,
  parameter int unsigned CNT_W     = $clog2(MAX_VALUE + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             sat_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_VALUE);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != MAX_CNT)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = (cnt_q == MAX_CNT);

endmodule

// File: rtl/sfence_vma_ctrl.sv
// SFENCE.VMA sequencer for the execute stage.
// Captures rs1/rs2 at issue, writes back a null result one cycle later, waits
// for commit, drains the store path and then fires a one-cycle TLB flush with
// the captured vaddr/ASID.
//   issue     : sfence_valid_i/sfence_ready_o, trans_id_i, rs1_i, rs2_i, rs*_zero_i
//   writeback : wb_valid_o, wb_trans_id_o
//   control   : flush_i (speculative kill), commit_i, no_st_pending_i, wbuffer_empty_i
//   to LSU    : flush_tlb_o, vaddr_o, asid_o, flush_all_vaddr_o, flush_all_asid_o
//   status    : busy_o, timeout_o (sticky drain timeout), sfence_count_o (perf)
module sfence_vma_ctrl
  import sfence_vma_ctrl_pkg::*;
#(
  parameter int unsigned ASID_WIDTH    = 1,
  parameter int unsigned DRAIN_TIMEOUT = 256,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     sfence_valid_i,
  output logic                     sfence_ready_o,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  input  logic [VLEN-1:0]          rs1_i,
  input  logic [ASID_WIDTH-1:0]    rs2_i,
  input  logic                     rs1_zero_i,
  input  logic                     rs2_zero_i,
  output logic                     wb_valid_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  input  logic                     commit_i,
  input  logic                     no_st_pending_i,
  input  logic                     wbuffer_empty_i,
  output logic                     flush_tlb_o,
  output logic [VLEN-1:0]          vaddr_o,
  output logic [ASID_WIDTH-1:0]    asid_o,
  output logic                     flush_all_vaddr_o,
  output logic                     flush_all_asid_o,
  output logic                     busy_o,
  output logic                     timeout_o,
  output logic [CNT_WIDTH-1:0]     sfence_count_o
);

  localparam int unsigned      DRAIN_CW     = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [DRAIN_CW-1:0] TIMEOUT_LAST = DRAIN_CW'(DRAIN_TIMEOUT - 1);

  sfence_state_e           state_q, state_d;
  sfence_req_t             req_q;
  logic                    capture;
  logic                    timeout_q;
  logic [CNT_WIDTH-1:0]    count_q;
  logic [DRAIN_CW-1:0]     drain_cnt;
  logic                    drain_sat;
  logic                    in_drain;

  always_comb begin
    state_d        = state_q;
    sfence_ready_o = 1'b0;
    wb_valid_o     = 1'b0;
    flush_tlb_o    = 1'b0;
    capture        = 1'b0;
    case (state_q)
      IDLE: begin
        sfence_ready_o = 1'b1;
        if (sfence_valid_i && !flush_i) begin
          capture = 1'b1;
          state_d = WB;
        end
      end
      WB: begin
        // Writeback is still presented on a kill; the scoreboard discards it.
        wb_valid_o = 1'b1;
        state_d    = flush_i ? IDLE : WAIT_COMMIT;
      end
      WAIT_COMMIT: begin
        if (commit_i) begin
          state_d = DRAIN;
        end else if (flush_i) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        // Committed: flush_i no longer applies here.
        if (no_st_pending_i && wbuffer_empty_i) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        flush_tlb_o = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q <= '0;
    end else if (capture) begin
      req_q.vaddr     <= rs1_i;
      req_q.asid      <= ASID_MAX_WIDTH'(rs2_i);
      req_q.all_vaddr <= rs1_zero_i;
      req_q.all_asid  <= rs2_zero_i;
      req_q.trans_id  <= trans_id_i;
    end
  end

  assign in_drain = (state_q == DRAIN);

  sfence_vma_ctrl_sat_counter #(
    .MAX_VALUE (DRAIN_TIMEOUT),
    .CNT_W     (DRAIN_CW)
  ) i_drain_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (!in_drain),
    .en_i   (in_drain),
    .cnt_o  (drain_cnt),
    .sat_o  (drain_sat)
  );

  // Set on the edge where the DRAIN_TIMEOUT-th drain cycle is counted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timeout_q <= 1'b0;
    end else if (capture) begin
      timeout_q <= 1'b0;
    end else if (in_drain && ((drain_cnt == TIMEOUT_LAST) || drain_sat)) begin
      timeout_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (state_q == FLUSH) begin
      count_q <= count_q + 1'b1;
    end
  end

  // ASID is stored zero-extended to the package maximum; only the low bits drive out.
  logic unused_asid_bits;
  assign unused_asid_bits = ^req_q.asid;

  assign wb_trans_id_o     = req_q.trans_id;
  assign vaddr_o           = req_q.vaddr;
  assign asid_o            = req_q.asid[ASID_WIDTH-1:0];
  assign flush_all_vaddr_o = req_q.all_vaddr;
  assign flush_all_asid_o  = req_q.all_asid;
  assign busy_o            = (state_q != IDLE);
  assign timeout_o         = timeout_q;
  assign sfence_count_o    = count_q;

  // Issuing while the controller is occupied is an upstream protocol error.
  assert property (@(posedge clk_i) disable iff (!rst_ni) sfence_valid_i |-> sfence_ready_o);

endmodule
